// File: rtl/rr_arb_mux_4.sv
// rtl/rr_arb_mux_4.sv - four-source round-robin arbiter feeding a registered valid/ready output stage
module rr_arb_mux_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     sel_q, sel_d;
    logic [W-1:0]   data_q, data_d;

    logic           any_valid;
    logic           can_load;
    logic           load;
    logic [1:0]     winner;
    logic [1:0]     scan_idx;
    logic           win_found;
    logic [W-1:0]   win_data;

    assign any_valid = |in_valid;
    assign can_load  = (state_q == EMPTY) | out_ready;
    assign load      = can_load & any_valid;

    // Scan starts one past the last winner, so the last winner is checked last.
    always_comb begin
        winner    = ptr_q;
        win_found = 1'b0;
        scan_idx  = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!win_found && in_valid[scan_idx]) begin
                winner    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = d0;
        case (winner)
            2'd0: win_data = d0;
            2'd1: win_data = d1;
            2'd2: win_data = d2;
            2'd3: win_data = d3;
            default: win_data = d0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            ptr_d  = winner;
            sel_d  = winner;
            data_d = win_data;
        end
    end

    // in_ready is forced low while reset is held so no source believes it was accepted.
    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = data_q;
        out_sel   = sel_q;
        in_ready  = 4'b0000;
        if (rst_n && load) begin
            in_ready[winner] = 1'b1;
        end
    end

endmodule
